// File: rtl/occ_gt_reset_pkg.sv
// Shared types and defaults for the OCC GT PHY reset sequencer.
package occ_gt_reset_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_GT_RST    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  localparam int C_NUM_LANES         = 32'd1;
  localparam int C_PLL_RST_CYCLES    = 32'd200;
  localparam int C_LOCK_STABLE_CYCLES = 32'd16;
  localparam int C_GT_RST_CYCLES     = 32'd8;
  localparam int C_TIMEOUT_CYCLES    = 32'd65535;
  localparam int C_MAX_RETRIES       = 32'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/occ_gt_sync.sv
// Two-flop synchroniser for asynchronous status inputs into init_clk.
module occ_gt_sync
  import occ_gt_reset_pkg::*;
#(
  parameter int g_WIDTH = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [g_WIDTH-1:0] d_i,
  output logic [g_WIDTH-1:0] q_o
);

  logic [g_WIDTH-1:0] meta_q;
  logic [g_WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/occ_gt_reset_seq.sv
// Reset sequencer for a shared-PLL GT quad: PLL reset, lock wait, GT reset,
// reset-done wait, with timeouts, bounded retry and per-lane RX-only reset.
module occ_gt_reset_seq
  import occ_gt_reset_pkg::*;
#(
  parameter int g_NUM_LANES          = C_NUM_LANES,
  parameter int g_PLL_RST_CYCLES     = C_PLL_RST_CYCLES,
  parameter int g_LOCK_STABLE_CYCLES = C_LOCK_STABLE_CYCLES,
  parameter int g_GT_RST_CYCLES      = C_GT_RST_CYCLES,
  parameter int g_TIMEOUT_CYCLES     = C_TIMEOUT_CYCLES,
  parameter int g_MAX_RETRIES        = C_MAX_RETRIES
) (
  input  logic                                 init_clk_i,
  input  logic                                 init_rst_i,
  input  logic                                 pll_lock_i,
  input  logic [g_NUM_LANES-1:0]               txresetdone_i,
  input  logic [g_NUM_LANES-1:0]               rxresetdone_i,
  input  logic                                 txreset_req_i,
  input  logic [g_NUM_LANES-1:0]               rxreset_req_i,
  output logic                                 pll_rst_o,
  output logic                                 gttxreset_o,
  output logic [g_NUM_LANES-1:0]               gtrxreset_o,
  output logic                                 txuserrdy_o,
  output logic [g_NUM_LANES-1:0]               rxuserrdy_o,
  output logic                                 ready_o,
  output logic [g_NUM_LANES-1:0]               lane_ready_o,
  output logic                                 fail_o,
  output logic [$clog2(g_MAX_RETRIES+1)-1:0]   retry_cnt_o,
  output logic [2:0]                           state_o
);

  localparam int CNT_W  = $clog2(max3(g_PLL_RST_CYCLES, g_GT_RST_CYCLES, g_TIMEOUT_CYCLES) + 1);
  localparam int STB_W  = $clog2(g_LOCK_STABLE_CYCLES + 1);
  localparam int LCNT_W = $clog2(g_GT_RST_CYCLES + 1);
  localparam int RTY_W  = $clog2(g_MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]  PLL_LAST  = CNT_W'(g_PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GT_LAST   = CNT_W'(g_GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(g_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(g_LOCK_STABLE_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LANE_LAST = LCNT_W'(g_GT_RST_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(g_MAX_RETRIES);

  logic                   lock_s;
  logic [g_NUM_LANES-1:0] txdone_s;
  logic [g_NUM_LANES-1:0] rxdone_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               timeout_s;
  logic               rx_acc_s;

  logic [g_NUM_LANES-1:0] lane_busy_q, lane_busy_d;

  logic                   pll_rst_q, pll_rst_d;
  logic                   gttx_q, gttx_d;
  logic [g_NUM_LANES-1:0] gtrx_q, gtrx_d;
  logic                   txu_q, txu_d;
  logic [g_NUM_LANES-1:0] rxu_q, rxu_d;
  logic                   ready_q, ready_d;
  logic [g_NUM_LANES-1:0] lane_rdy_q, lane_rdy_d;
  logic                   fail_q, fail_d;

  occ_gt_sync #(.g_WIDTH(1)) u_sync_lock (
    .clk_i (init_clk_i),
    .rst_i (init_rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  occ_gt_sync #(.g_WIDTH(2 * g_NUM_LANES)) u_sync_done (
    .clk_i (init_clk_i),
    .rst_i (init_rst_i),
    .d_i   ({txresetdone_i, rxresetdone_i}),
    .q_o   ({txdone_s, rxdone_s})
  );

  always_comb begin
    state_d   = state_q;
    stable_d  = '0;
    retry_d   = retry_q;
    timeout_s = 1'b0;
    if (txreset_req_i) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
          else                   state_d = ST_PLL_RST;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) stable_d = stable_q + 1'b1;
          else        stable_d = '0;
          if (lock_s && (stable_q == STB_LAST)) state_d = ST_GT_RST;
          else if (cnt_q == TO_LAST)            timeout_s = 1'b1;
          else                                  state_d = ST_WAIT_LOCK;
        end
        ST_GT_RST: begin
          if (cnt_q == GT_LAST) state_d = ST_WAIT_DONE;
          else                  state_d = ST_GT_RST;
        end
        ST_WAIT_DONE: begin
          if ((&txdone_s) && (&rxdone_s)) state_d = ST_READY;
          else if (cnt_q == TO_LAST)      timeout_s = 1'b1;
          else                            state_d = ST_WAIT_DONE;
        end
        ST_READY: begin
          retry_d = '0;
          if (!lock_s) state_d = ST_PLL_RST;
          else         state_d = ST_READY;
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_PLL_RST;
      endcase
      // A timeout that exhausts the retry budget parks the sequencer in FAIL.
      if (timeout_s) begin
        retry_d = retry_q + 1'b1;
        if (retry_d == RTY_MAX) state_d = ST_FAIL;
        else                    state_d = ST_PLL_RST;
      end else begin
        retry_d = retry_d;
      end
    end

    if (txreset_req_i || (state_d != state_q)) begin
      cnt_d    = '0;
      stable_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // RX-only lane resets are honoured only while the link stays in READY.
  assign rx_acc_s = (state_q == ST_READY) && (state_d == ST_READY);

  for (genvar k = 0; k < g_NUM_LANES; k++) begin : g_lane
    logic [LCNT_W-1:0] lane_cnt_q, lane_cnt_d;
    logic              busy_nxt;

    always_comb begin
      busy_nxt   = lane_busy_q[k];
      lane_cnt_d = lane_cnt_q;
      if (!rx_acc_s) begin
        busy_nxt   = 1'b0;
        lane_cnt_d = '0;
      end else if (rxreset_req_i[k]) begin
        busy_nxt   = 1'b1;
        lane_cnt_d = '0;
      end else if (lane_busy_q[k] && (lane_cnt_q == LANE_LAST)) begin
        busy_nxt   = 1'b0;
        lane_cnt_d = '0;
      end else if (lane_busy_q[k]) begin
        busy_nxt   = 1'b1;
        lane_cnt_d = lane_cnt_q + 1'b1;
      end else begin
        busy_nxt   = 1'b0;
        lane_cnt_d = '0;
      end
    end

    always_ff @(posedge init_clk_i) begin
      if (init_rst_i) lane_cnt_q <= '0;
      else            lane_cnt_q <= lane_cnt_d;
    end

    assign lane_busy_d[k] = busy_nxt;
  end

  // Outputs are decoded from the next state so they register on the transition edge.
  always_comb begin
    pll_rst_d = 1'b0;
    gttx_d    = 1'b0;
    gtrx_d    = '0;
    txu_d     = 1'b0;
    rxu_d     = '0;
    ready_d   = 1'b0;
    fail_d    = 1'b0;
    case (state_d)
      ST_PLL_RST: begin
        pll_rst_d = 1'b1;
        gttx_d    = 1'b1;
        gtrx_d    = '1;
      end
      ST_WAIT_LOCK, ST_GT_RST: begin
        gttx_d = 1'b1;
        gtrx_d = '1;
      end
      ST_WAIT_DONE: begin
        txu_d = 1'b1;
        rxu_d = '1;
      end
      ST_READY: begin
        txu_d   = 1'b1;
        rxu_d   = ~lane_busy_d;
        gtrx_d  = lane_busy_d;
        ready_d = 1'b1;
      end
      ST_FAIL: begin
        pll_rst_d = 1'b1;
        gttx_d    = 1'b1;
        gtrx_d    = '1;
        fail_d    = 1'b1;
      end
      default: begin
        pll_rst_d = 1'b1;
        gttx_d    = 1'b1;
        gtrx_d    = '1;
      end
    endcase
    lane_rdy_d = {g_NUM_LANES{ready_d}} & ~lane_busy_d & rxdone_s;
  end

  always_ff @(posedge init_clk_i) begin
    if (init_rst_i) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      lane_busy_q <= '0;
      pll_rst_q   <= 1'b1;
      gttx_q      <= 1'b1;
      gtrx_q      <= '1;
      txu_q       <= 1'b0;
      rxu_q       <= '0;
      ready_q     <= 1'b0;
      lane_rdy_q  <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      lane_busy_q <= lane_busy_d;
      pll_rst_q   <= pll_rst_d;
      gttx_q      <= gttx_d;
      gtrx_q      <= gtrx_d;
      txu_q       <= txu_d;
      rxu_q       <= rxu_d;
      ready_q     <= ready_d;
      lane_rdy_q  <= lane_rdy_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign gttxreset_o  = gttx_q;
  assign gtrxreset_o  = gtrx_q;
  assign txuserrdy_o  = txu_q;
  assign rxuserrdy_o  = rxu_q;
  assign ready_o      = ready_q;
  assign lane_ready_o = lane_rdy_q;
  assign fail_o       = fail_q;
  assign retry_cnt_o  = retry_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_occ_gt_reset_seq.sv
// Directed bench for occ_gt_reset_seq: cycle-accurate vector table for
// bring-up, RX lane resets and lock loss, plus timeout/retry/FAIL sequences.
module tb_occ_gt_reset_seq;

  typedef struct {
    int          n;
    logic        lock;
    logic [1:0]  txd;
    logic [1:0]  rxd;
    logic        txreq;
    logic [1:0]  rxreq;
    logic [15:0] exp;
  } vec_t;

  logic       clk;
  logic       init_rst;
  logic       lock;
  logic [1:0] txd;
  logic [1:0] rxd;
  logic       txreq;
  logic [1:0] rxreq;

  logic       pll_rst, gttx, txu, rdy, fl;
  logic [1:0] gtrx, rxu, lr, rty;
  logic [2:0] st;
  logic [15:0] act;

  int checks = 0;
  int fails  = 0;
  vec_t vecs[$];

  logic [15:0] e_prst, e_wl, e_gt, e_wd, e_rdy, e_fail;

  occ_gt_reset_seq #(
    .g_NUM_LANES(2), .g_PLL_RST_CYCLES(10), .g_LOCK_STABLE_CYCLES(4),
    .g_GT_RST_CYCLES(3), .g_TIMEOUT_CYCLES(50), .g_MAX_RETRIES(3)
  ) dut (
    .init_clk_i    (clk),
    .init_rst_i    (init_rst),
    .pll_lock_i    (lock),
    .txresetdone_i (txd),
    .rxresetdone_i (rxd),
    .txreset_req_i (txreq),
    .rxreset_req_i (rxreq),
    .pll_rst_o     (pll_rst),
    .gttxreset_o   (gttx),
    .gtrxreset_o   (gtrx),
    .txuserrdy_o   (txu),
    .rxuserrdy_o   (rxu),
    .ready_o       (rdy),
    .lane_ready_o  (lr),
    .fail_o        (fl),
    .retry_cnt_o   (rty),
    .state_o       (st)
  );

  assign act = {pll_rst, gttx, gtrx, txu, rxu, rdy, lr, fl, rty, st};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ex(logic p, logic tx, logic [1:0] grx, logic tu,
                                     logic [1:0] ru, logic r, logic [1:0] l,
                                     logic f, logic [1:0] rc, logic [2:0] s);
    return {p, tx, grx, tu, ru, r, l, f, rc, s};
  endfunction

  function automatic vec_t mk(int n, logic lk, logic [1:0] t, logic [1:0] r,
                              logic tq, logic [1:0] rq, logic [15:0] e);
    vec_t v;
    v.n = n; v.lock = lk; v.txd = t; v.rxd = r; v.txreq = tq; v.rxreq = rq; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] e);
    checks++;
    if (act !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (pll,gttx,gtrx,txu,rxu,rdy,lr,fail,retry,state)",
               name, act, e);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    checks++;
    while (st !== s && n < budget) begin
      tick();
      n++;
    end
    if (st !== s) begin
      fails++;
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", name, st, s, budget);
    end
  endtask

  initial begin
    init_rst = 1'b1;
    lock = 1'b0; txd = 2'b00; rxd = 2'b00; txreq = 1'b0; rxreq = 2'b00;

    e_prst = ex(1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 3'd0);
    e_wl   = ex(1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 3'd1);
    e_gt   = ex(1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 3'd2);
    e_wd   = ex(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'd0, 3'd3);
    e_rdy  = ex(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 2'd0, 3'd4);
    e_fail = ex(1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'd3, 3'd5);

    // bring-up: pll_rst high for exactly 10 cycles, then lock, GT reset, done
    vecs.push_back(mk(9, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, e_prst));
    vecs.push_back(mk(1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, e_wl));
    vecs.push_back(mk(5, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, e_wl));
    vecs.push_back(mk(1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, e_gt));
    vecs.push_back(mk(2, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, e_gt));
    vecs.push_back(mk(1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, e_wd));
    vecs.push_back(mk(2, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, e_wd));
    vecs.push_back(mk(2, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, e_wd));
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, e_rdy));
    vecs.push_back(mk(5, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, e_rdy));
    // RX-only reset of lane 1; done for that lane drops and later returns
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b01, 1'b0, 2'b10,
                      ex(1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(2, 1'b1, 2'b11, 2'b01, 1'b0, 2'b00,
                      ex(1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b01, 1'b0, 2'b00,
                      ex(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(2, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00,
                      ex(1'b0, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, e_rdy));
    // lane 0 request repeated mid-pulse restarts its 3-cycle reset
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b01,
                      ex(1'b0, 1'b0, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00,
                      ex(1'b0, 1'b0, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b01,
                      ex(1'b0, 1'b0, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(2, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00,
                      ex(1'b0, 1'b0, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 2'd0, 3'd4)));
    vecs.push_back(mk(1, 1'b1, 2'b11, 2'b11, 1'b0, 2'b00, e_rdy));
    // lock loss in READY: ready drops on the third edge after the fall
    vecs.push_back(mk(2, 1'b0, 2'b11, 2'b11, 1'b0, 2'b00, e_rdy));
    vecs.push_back(mk(1, 1'b0, 2'b11, 2'b11, 1'b0, 2'b00, e_prst));

    repeat (3) tick();
    check("reset_values", e_prst);
    init_rst = 1'b0;

    foreach (vecs[i]) begin
      lock  = vecs[i].lock;
      txd   = vecs[i].txd;
      rxd   = vecs[i].rxd;
      txreq = vecs[i].txreq;
      rxreq = vecs[i].rxreq;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // lock glitch in WAIT_LOCK: 3 high, 1 low, then 4 high needed
    wait_state(3'd1, 20, "enter_wait_lock");
    lock = 1'b1;
    repeat (3) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    repeat (5) tick();
    check("glitch_still_waiting", e_wl);
    tick();
    check("glitch_gt_rst", e_gt);
    wait_state(3'd4, 20, "ready_after_glitch");
    check("ready_after_glitch_outputs", e_rdy);

    // simultaneous full restart and lane-0 RX request: restart wins
    txreq = 1'b1;
    rxreq = 2'b01;
    tick();
    txreq = 1'b0;
    rxreq = 2'b00;
    check("txreq_beats_rxreq", e_prst);

    // lock never arrives: three timeouts, retry 1, 2, then FAIL
    lock = 1'b0;
    txd  = 2'b00;
    rxd  = 2'b00;
    for (int r = 1; r <= 3; r++) begin
      wait_state(3'd1, 20, $sformatf("to%0d_enter", r));
      repeat (49) tick();
      check($sformatf("to%0d_hold", r),
            ex(1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'(r - 1), 3'd1));
      tick();
      if (r < 3) check($sformatf("to%0d_retry", r),
                       ex(1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'(r), 3'd0));
      else       check("to3_fail", e_fail);
    end
    repeat (5) tick();
    check("fail_hold", e_fail);
    txreq = 1'b1;
    tick();
    txreq = 1'b0;
    check("fail_exit_txreq", e_prst);

    // reset-done never arrives: WAIT_DONE times out after 50 cycles
    lock = 1'b1;
    wait_state(3'd3, 40, "enter_wait_done");
    repeat (49) tick();
    check("wd_timeout_hold", e_wd);
    tick();
    check("wd_timeout_retry",
          ex(1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd1, 3'd0));

    init_rst = 1'b1;
    tick();
    check("sync_reset_midrun", e_prst);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
